ahb2apb_bridge: RTL and testbench
=================================

Name: ahb2apb_bridge

Overview:
- AHB-Lite slave that sits downstream of the AHB decoder/multiplexor, in place of one ahb_slave instance.
- Converts each accepted AHB transfer into exactly one APB3 transfer, with SETUP and ACCESS phases.
- Returns the read data and response to the AHB multiplexor through hrdata, hreadyout and hresp.
- APB runs on the same clock as AHB (pclk = hclk).

Parameters:
- ADDR_W, 32, AHB address width.
- DATA_W, 32, data width on both AHB and APB sides.
- PADDR_W, 16, APB address width; paddr = haddr[PADDR_W-1:0].
- TIMEOUT, 16, maximum ACCESS cycles allowed with pready low. Used only with BRIDGE_TIMEOUT_EN.

Ports:
- hclk  in  1  clock for both AHB and APB sides.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from the decoder.
- haddr  in  ADDR_W  AHB address.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- htrans  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- hready  in  1  bus-wide ready.
- hwdata  in  DATA_W  write data, valid one cycle after the address phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_W  read data.
- paddr  out  PADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low on hresetn.
- Reset values: hreadyout=1, hresp=0, hrdata=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0, FSM=IDLE. All outputs are registered.
- Acceptance: a transfer is accepted at a rising edge where hsel & hready & htrans[1] = 1. At acceptance, haddr[PADDR_W-1:0] and hwrite are latched.
- IDLE or BUSY with hsel=1: zero-wait OKAY; no APB activity.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE transitions:
  - Accept read -> SETUP.
  - Accept write -> WDATA.
  - Accept with hsize>2 -> ERR1, with no APB access.
  - hreadyout goes 0 in the cycle after any acceptance.
- WDATA: hwdata is captured into pwdata; -> SETUP.
- SETUP: psel=1, penable=0, paddr and pwrite valid; -> ACCESS.
- ACCESS: psel=1, penable=1; held while pready=0.
  - On pready=1 & pslverr=0: -> IDLE. Next cycle psel=0, penable=0, hreadyout=1, hresp=0; for reads, hrdata = prdata sampled at that edge.
  - On pready=1 & pslverr=1: -> ERR1.
- Two-cycle AHB error: ERR1 drives hresp=1, hreadyout=0. ERR2 drives hresp=1, hreadyout=1. Then -> IDLE with hresp=0.
- Latency from address phase N, with pready=1 on first ACCESS:
  - Read: hreadyout=1 with data at N+3.
  - Write: completes at N+4.
- Back-to-back transfers: while hreadyout=0, the master extends the next address phase. It is accepted on the edge where hreadyout (hence hready) returns 1.
- hrdata holds its last value between reads.
- pwdata and paddr hold their values after a transfer; psel and penable deassert.
- No transfer is ever dropped or duplicated. Exactly one psel rising edge occurs per accepted valid transfer.
- Reset asserted mid-transfer: all outputs return to reset values immediately, including psel and penable.

Optional Feature:
- Macro: BRIDGE_TIMEOUT_EN.
- When defined:
  - A wait counter clears on SETUP and increments for each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT, psel and penable drop and the FSM goes to ERR1, giving a two-cycle AHB ERROR.
  - A later pready is ignored.
- When undefined: ACCESS waits indefinitely; there is no counter logic.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ encodings.
  - HRESP_OKAY/ERROR.
  - The bridge state encoding, including ERR1 and ERR2.
- One natural sub-module: apb_wait_timer, the timeout counter. It is instantiated only under BRIDGE_TIMEOUT_EN.

Test Plan:
- Read: NONSEQ read, haddr=0x0000_1234, pready=1 first cycle, prdata=0xDEAD_BEEF -> paddr=0x1234, psel at N+1, penable at N+2; hrdata=0xDEAD_BEEF, hreadyout=1, hresp=0 at N+3.
- Write with wait states: NONSEQ write, haddr=0x10, hwdata=0xA5A5_0F0F, pready low for 3 ACCESS cycles -> pwdata=0xA5A5_0F0F, pwrite=1, penable held 4 cycles, hreadyout=1 one cycle after pready.
- Slave error: read with pslverr=1 on pready -> hresp=1 for exactly 2 cycles, hreadyout 0 then 1, then hresp=0.
- Non-transfers and bad size: htrans=IDLE or BUSY with hsel=1 -> no psel, hreadyout stays 1. hsize=3'b011 -> two-cycle ERROR, psel never asserted.
- Back-to-back: write 0x20 then read 0x24 issued consecutively -> second address phase stalled, exactly two APB transfers in order, no gap violation (psel low ≥1 cycle between them).
- Reset and timeout: hresetn low during ACCESS -> psel=0, penable=0, hreadyout=1 at once. With BRIDGE_TIMEOUT_EN, TIMEOUT=4 and pready stuck 0 -> ERROR after 4 ACCESS cycles.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// ============================================================================
// Module   : ahb_apb_pkg
// Brief    : Shared AHB/APB encodings and bridge state type for ahb2apb_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  // NONSEQ and SEQ carry data; IDLE and BUSY are answered without APB activity.
  function automatic logic is_xfer(input logic [1:0] trans);
    return (trans != HTRANS_IDLE) && (trans != HTRANS_BUSY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module   : apb_wait_timer
// Brief    : Counts ACCESS cycles with pready low; flags the cycle the limit hits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the stalled cycle that would bring the count up to TIMEOUT.
  assign expired_o = count_en_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/ahb2apb_bridge.sv
// ============================================================================
// Module   : ahb2apb_bridge
// Brief    : AHB-Lite slave converting each accepted transfer into one APB3
//            transfer. Optional ACCESS timeout enabled by BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb2apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [1:0]         htrans,
  input  logic               hready,
  input  logic [DATA_W-1:0]  hwdata,
  output logic               hreadyout,
  output logic               hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic [PADDR_W-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  import ahb_apb_pkg::*;

  bridge_state_e      state_q, state_d;
  logic               accept_w;
  logic               timeout_w;
  logic               hreadyout_q;
  logic               hresp_q;
  logic               psel_q;
  logic               penable_q;
  logic               pwrite_q, pwrite_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;
  logic               unused_addr;

  assign unused_addr = ^haddr[ADDR_W-1:PADDR_W];

  // ERR2 already shows hreadyout=1, so a pipelined address phase may land there.
  assign accept_w = hsel && hready && is_xfer(htrans)
                    && ((state_q == ST_IDLE) || (state_q == ST_ERR2));

`ifdef BRIDGE_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i      (hclk),
    .rst_ni     (hresetn),
    .clear_i    (state_q == ST_SETUP),
    .count_en_i ((state_q == ST_ACCESS) && !pready),
    .expired_o  (timeout_w)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_w      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_w) begin
          paddr_d  = haddr[PADDR_W-1:0];
          pwrite_d = hwrite;
          if (hsize > 3'd2) begin
            state_d = ST_ERR1;
          end else if (hwrite) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_WDATA: begin
        pwdata_d = hwdata;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_IDLE;
            if (!pwrite_q) begin
              hrdata_d = prdata;
            end
          end
        end else if (timeout_w) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered as a decode of the next state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= (state_d == ST_IDLE) || (state_d == ST_ERR2);
      hresp_q     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q   <= (state_d == ST_ACCESS);
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
// ============================================================================
// Module   : tb_ahb2apb_bridge
// Brief    : Directed self-checking bench for ahb2apb_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb2apb_bridge;

  import ahb_apb_pkg::*;

  localparam int NC = 44;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  ahb2apb_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .PADDR_W (16),
    .TIMEOUT (4)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .htrans    (htrans),
    .hready    (hready),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign hready = hreadyout;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Per-cycle stimulus plan.
  logic        a_sel[NC];
  logic [1:0]  a_trans[NC];
  logic [31:0] a_addr[NC];
  logic        a_wr[NC];
  logic [2:0]  a_size[NC];
  logic [31:0] a_wdata[NC];
  logic        a_pready[NC];
  logic [31:0] a_prdata[NC];
  logic        a_pslverr[NC];

  // Expected values: control per cycle, data-path registers as change events.
  logic        e_psel[NC], e_pen[NC], e_hrdy[NC], e_hresp[NC];
  logic        ev_paddr[NC], ev_pwdata[NC], ev_hrdata[NC];
  logic [15:0] v_paddr[NC];
  logic        v_pwrite[NC];
  logic [31:0] v_pwdata[NC], v_hrdata[NC];
  logic [15:0] f_paddr[NC];
  logic        f_pwrite[NC];
  logic [31:0] f_pwdata[NC], f_hrdata[NC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, c, act, exp);
  endtask

  // Transaction-level model: an address phase held from 'from' and accepted at
  // the end of cycle n; APB slave answers after 'waits' stalled ACCESS cycles.
  task automatic plan(input int from, input int n, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input int waits, input logic slverr, input logic bad);
    int s;
    int d;
    for (int c = from; c <= n; c++) begin
      a_sel[c]   = 1'b1;
      a_trans[c] = HTRANS_NONSEQ;
      a_addr[c]  = addr;
      a_wr[c]    = wr;
      a_size[c]  = bad ? 3'b011 : 3'b010;
    end
    ev_paddr[n+1] = 1'b1;
    v_paddr[n+1]  = addr[15:0];
    v_pwrite[n+1] = wr;
    if (bad) begin
      e_hrdy[n+1]  = 1'b0;
      e_hresp[n+1] = 1'b1;
      e_hresp[n+2] = 1'b1;
      return;
    end
    if (wr) a_wdata[n+1] = data;
    s = n + 1 + (wr ? 1 : 0);
    d = s + 2 + waits;
    for (int c = n + 1; c < d; c++) e_hrdy[c] = 1'b0;
    e_psel[s] = 1'b1;
    for (int c = s + 1; c < d; c++) begin
      e_psel[c]   = 1'b1;
      e_pen[c]    = 1'b1;
      a_pready[c] = (c == d - 1);
    end
    a_prdata[d-1]  = data;
    a_pslverr[d-1] = slverr;
    if (wr) begin
      ev_pwdata[s] = 1'b1;
      v_pwdata[s]  = data;
    end
    if (slverr) begin
      e_hrdy[d]    = 1'b0;
      e_hresp[d]   = 1'b1;
      e_hresp[d+1] = 1'b1;
    end else if (!wr) begin
      ev_hrdata[d] = 1'b1;
      v_hrdata[d]  = data;
    end
  endtask

  task automatic drive(input int c);
    hsel    = a_sel[c];
    htrans  = a_trans[c];
    haddr   = a_addr[c];
    hwrite  = a_wr[c];
    hsize   = a_size[c];
    hwdata  = a_wdata[c];
    pready  = a_pready[c];
    prdata  = a_prdata[c];
    pslverr = a_pslverr[c];
  endtask

  task automatic idle_inputs();
    hsel    = 1'b0;
    htrans  = HTRANS_IDLE;
    haddr   = 32'h0;
    hwrite  = 1'b0;
    hsize   = 3'b010;
    hwdata  = 32'h0;
    pready  = 1'b0;
    prdata  = 32'h0;
    pslverr = 1'b0;
  endtask

  initial begin
    logic [15:0] cur_paddr;
    logic        cur_pwrite;
    logic [31:0] cur_pwdata;
    logic [31:0] cur_hrdata;

    for (int c = 0; c < NC; c++) begin
      a_sel[c] = 1'b0; a_trans[c] = HTRANS_IDLE; a_addr[c] = 32'h0; a_wr[c] = 1'b0;
      a_size[c] = 3'b010; a_wdata[c] = 32'hCAFE_0000 | c; a_pready[c] = 1'b0;
      a_prdata[c] = 32'h0; a_pslverr[c] = 1'b0;
      e_psel[c] = 1'b0; e_pen[c] = 1'b0; e_hrdy[c] = 1'b1; e_hresp[c] = 1'b0;
      ev_paddr[c] = 1'b0; ev_pwdata[c] = 1'b0; ev_hrdata[c] = 1'b0;
      v_paddr[c] = 16'h0; v_pwrite[c] = 1'b0; v_pwdata[c] = 32'h0; v_hrdata[c] = 32'h0;
    end

    plan( 2,  2, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 0, 1'b0, 1'b0); // read
    plan( 7,  7, 1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 3, 1'b0, 1'b0); // write, 3 waits
    plan(16, 16, 1'b0, 32'h0000_0040, 32'hBAD0_BAD0, 0, 1'b1, 1'b0); // slave error
    for (int c = 22; c <= 25; c++) begin
      a_sel[c]   = 1'b1;
      a_trans[c] = (c < 24) ? HTRANS_IDLE : HTRANS_BUSY;
      a_addr[c]  = 32'h0000_0077;
    end
    plan(27, 27, 1'b1, 32'h0000_0030, 32'h0, 0, 1'b0, 1'b1);         // hsize=3
    plan(31, 31, 1'b1, 32'h0000_0020, 32'h1111_2222, 0, 1'b0, 1'b0); // back-to-back write
    plan(32, 35, 1'b0, 32'h4000_0024, 32'h3333_4444, 1, 1'b0, 1'b0); // ...then stalled read

    cur_paddr = 16'h0; cur_pwrite = 1'b0; cur_pwdata = 32'h0; cur_hrdata = 32'h0;
    for (int c = 0; c < NC; c++) begin
      if (ev_paddr[c])  begin cur_paddr = v_paddr[c]; cur_pwrite = v_pwrite[c]; end
      if (ev_pwdata[c]) cur_pwdata = v_pwdata[c];
      if (ev_hrdata[c]) cur_hrdata = v_hrdata[c];
      f_paddr[c] = cur_paddr; f_pwrite[c] = cur_pwrite;
      f_pwdata[c] = cur_pwdata; f_hrdata[c] = cur_hrdata;
    end

    // Reset values.
    hresetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hreadyout", -1, 32'(hreadyout), 32'h1);
    chk("rst_hresp",     -1, 32'(hresp),     32'h0);
    chk("rst_hrdata",    -1, hrdata,         32'h0);
    chk("rst_paddr",     -1, 32'(paddr),     32'h0);
    chk("rst_psel",      -1, 32'(psel),      32'h0);
    chk("rst_penable",   -1, 32'(penable),   32'h0);
    chk("rst_pwrite",    -1, 32'(pwrite),    32'h0);
    chk("rst_pwdata",    -1, pwdata,         32'h0);
    hresetn = 1'b1;

    for (int c = 0; c < NC; c++) begin
      @(posedge hclk);
      #1;
      drive(c);
      @(negedge hclk);
      chk("psel",      c, 32'(psel),      32'(e_psel[c]));
      chk("penable",   c, 32'(penable),   32'(e_pen[c]));
      chk("hreadyout", c, 32'(hreadyout), 32'(e_hrdy[c]));
      chk("hresp",     c, 32'(hresp),     32'(e_hresp[c]));
      chk("paddr",     c, 32'(paddr),     32'(f_paddr[c]));
      chk("pwrite",    c, 32'(pwrite),    32'(f_pwrite[c]));
      chk("pwdata",    c, pwdata,         f_pwdata[c]);
      chk("hrdata",    c, hrdata,         f_hrdata[c]);
      // Hand-derived anchors for the model.
      if (c == 3)  chk("lit_rd_paddr",  c, 32'(paddr),     32'h0000_1234);
      if (c == 4)  chk("lit_rd_pen",    c, 32'(penable),   32'h1);
      if (c == 5)  chk("lit_rd_hrdata", c, hrdata,         32'hDEAD_BEEF);
      if (c == 13) chk("lit_wr_pwdata", c, pwdata,         32'hA5A5_0F0F);
      if (c == 14) chk("lit_wr_done",   c, 32'(hreadyout), 32'h1);
      if (c == 20) chk("lit_err2_resp", c, 32'(hresp),     32'h1);
      if (c == 21) chk("lit_err_end",   c, 32'(hresp),     32'h0);
      if (c == 39) chk("lit_b2b_hrdata",c, hrdata,         32'h3333_4444);
    end

    // Reset asserted during ACCESS.
    @(posedge hclk); #1;
    idle_inputs();
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_0050;
    @(posedge hclk); #1;
    idle_inputs();
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("rst_mid_pre_pen", 0, 32'(penable), 32'h1);
    #2 hresetn = 1'b0;
    #1;
    chk("rst_mid_psel",      0, 32'(psel),      32'h0);
    chk("rst_mid_penable",   0, 32'(penable),   32'h0);
    chk("rst_mid_hreadyout", 0, 32'(hreadyout), 32'h1);
    chk("rst_mid_hrdata",    0, hrdata,         32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

`ifdef BRIDGE_TIMEOUT_EN
    // pready stuck low: ERROR after 4 ACCESS cycles, later pready ignored.
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_0060;
    @(posedge hclk); #1;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("to_access_pen", k, 32'(penable), 32'h1);
    end
    @(posedge hclk); #1;
    pready = 1'b1;
    @(negedge hclk);
    chk("to_err1_psel", 0, 32'(psel),      32'h0);
    chk("to_err1_resp", 0, 32'(hresp),     32'h1);
    chk("to_err1_rdy",  0, 32'(hreadyout), 32'h0);
    @(posedge hclk); #1;
    pready = 1'b0;
    @(negedge hclk);
    chk("to_err2_resp", 0, 32'(hresp),     32'h1);
    chk("to_err2_rdy",  0, 32'(hreadyout), 32'h1);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("to_end_resp",  0, 32'(hresp),     32'h0);
    chk("to_end_psel",  0, 32'(psel),      32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
